vpu_vec_engine: RTL and testbench

- Multi-lane, multi-beat successor to the scalar VPU controller.
- Accepts one 32-bit vector instruction over a valid/ready handshake. Reads LANES-wide operand words from vector memory and applies a per-lane ALU op. Writes results back over a streaming length of 1..2^LEN_W beats.
- Sits between the instruction issue queue and the vector scratchpad; one read port and one write port, one outstanding read.

---
 rtl/vpu_pkg.sv | 76 +++++++
 rtl/vpu_lane_alu.sv | 29 ++
 rtl/vpu_vec_engine.sv | 165 ++++++++++++++++
 tb/tb_vpu_vec_engine.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared types and helpers for the vector engine.
// Holds the fixed widths, opcode/state enums, the packed instruction layout
// and the opcode-class predicates used by the controller.
package vpu_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned INST_ADDR = 5;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned INST_W    = OP_W + 4 * INST_ADDR + LEN_W;
  localparam int unsigned WORD_W    = LANES * DATA_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = OP_W'(0),
    OP_SUB  = OP_W'(1),
    OP_ADDC = OP_W'(2),
    OP_MUL  = OP_W'(3),
    OP_MAX  = OP_W'(4),
    OP_MIN  = OP_W'(5),
    OP_RELU = OP_W'(6),
    OP_MULC = OP_W'(7)
  } op_t;

  // Field order matches the instruction word, MSB first.
  typedef struct packed {
    logic [LEN_W-1:0]     len;
    logic [INST_ADDR-1:0] const_addr;
    logic [INST_ADDR-1:0] c_addr;
    logic [INST_ADDR-1:0] b_addr;
    logic [INST_ADDR-1:0] a_addr;
    logic [OP_W-1:0]      opcode;
  } vpu_inst_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_K_REQ,
    S_K_WAIT,
    S_A_REQ,
    S_A_WAIT,
    S_B_REQ,
    S_B_WAIT,
    S_EXEC,
    S_WR,
    S_DONE
  } state_t;

  // Codes 8-15 have the top opcode bit set.
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

  // Ops that need a second vector operand fetched per beat.
  function automatic logic uses_b(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_MAX, OP_MIN: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops that need the broadcast constant fetched once per instruction.
  function automatic logic uses_k(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADDC, OP_MULC: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vpu_lane_alu.sv
// One-lane combinational ALU.
// Ports: opcode (op select), a/b (lane operands), k (broadcast constant),
//        result_c (truncated two's complement result, 0 for illegal ops).
module vpu_lane_alu
  import vpu_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] k,
  output logic [DATA_W-1:0] result_c
);

  always_comb begin
    result_c = '0;
    case (opcode)
      OP_ADD:  result_c = a + b;
      OP_SUB:  result_c = a - b;
      OP_ADDC: result_c = a + k;
      OP_MUL:  result_c = DATA_W'(a * b);
      OP_MAX:  result_c = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN:  result_c = ($signed(a) < $signed(b)) ? a : b;
      OP_RELU: result_c = a[DATA_W-1] ? '0 : a;
      OP_MULC: result_c = DATA_W'(a * k);
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/vpu_vec_engine.sv
// Multi-lane, multi-beat vector engine.
// Ports: clk/rst (async active-high); inst/inst_valid/inst_ready instruction
//        handshake; rd_req_valid/rd_req_ready/rd_addr read request;
//        rd_resp_valid/rd_resp_data read response; wr_valid/wr_ready/
//        wr_addr/wr_data write channel; busy, done (retire pulse), err
//        (illegal opcode, valid with done).
module vpu_vec_engine
  import vpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_resp_valid,
  input  logic [WORD_W-1:0] rd_resp_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  vpu_inst_t         inst_q, inst_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] k_q, k_d;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d;
  logic [WORD_W-1:0] res_c, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;
  logic              rd_req_valid_d, wr_valid_d, busy_d, done_d, err_d;

  assign inst_ready = (state_q == S_IDLE);

  // Per-lane ALUs share the opcode and the broadcast constant.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vpu_lane_alu u_alu (
      .opcode   (inst_q.opcode),
      .a        (a_q[i*DATA_W +: DATA_W]),
      .b        (b_q[i*DATA_W +: DATA_W]),
      .k        (k_q),
      .result_c (res_c[i*DATA_W +: DATA_W])
    );
  end

  // Next-state, datapath capture and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    beat_d    = beat_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    wr_data_d = wr_data;

    case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          inst_d = vpu_inst_t'(inst);
          beat_d = '0;
          if (is_illegal(inst_d.opcode))  state_d = S_DONE;
          else if (uses_k(inst_d.opcode)) state_d = S_K_REQ;
          else                            state_d = S_A_REQ;
        end
      end
      S_K_REQ: if (rd_req_ready) state_d = S_K_WAIT;
      S_K_WAIT: begin
        if (rd_resp_valid) begin
          k_d     = rd_resp_data[DATA_W-1:0];
          state_d = S_A_REQ;
        end
      end
      S_A_REQ: if (rd_req_ready) state_d = S_A_WAIT;
      S_A_WAIT: begin
        if (rd_resp_valid) begin
          a_d     = rd_resp_data;
          state_d = uses_b(inst_q.opcode) ? S_B_REQ : S_EXEC;
        end
      end
      S_B_REQ: if (rd_req_ready) state_d = S_B_WAIT;
      S_B_WAIT: begin
        if (rd_resp_valid) begin
          b_d     = rd_resp_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wr_data_d = res_c;
        state_d   = S_WR;
      end
      S_WR: begin
        if (wr_ready) begin
          if (beat_q == inst_q.len) begin
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + LEN_W'(1);
            state_d = S_A_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    rd_req_valid_d = (state_d == S_K_REQ) || (state_d == S_A_REQ) || (state_d == S_B_REQ);
    wr_valid_d     = (state_d == S_WR);
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
    err_d          = (state_d == S_DONE) && is_illegal(inst_d.opcode);

    // Addresses wrap modulo 2^ADDR_W through the truncating add.
    rd_addr_d = rd_addr;
    case (state_d)
      S_K_REQ: rd_addr_d = ADDR_W'(inst_d.const_addr);
      S_A_REQ: rd_addr_d = ADDR_W'(inst_d.a_addr) + ADDR_W'(beat_d);
      S_B_REQ: rd_addr_d = ADDR_W'(inst_d.b_addr) + ADDR_W'(beat_d);
      default: rd_addr_d = rd_addr;
    endcase

    wr_addr_d = wr_addr;
    if (state_d == S_WR) wr_addr_d = ADDR_W'(inst_d.c_addr) + ADDR_W'(beat_d);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      inst_q       <= '0;
      beat_q       <= '0;
      k_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rd_req_valid <= 1'b0;
      rd_addr      <= '0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      beat_q       <= beat_d;
      k_q          <= k_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rd_req_valid <= rd_req_valid_d;
      rd_addr      <= rd_addr_d;
      wr_valid     <= wr_valid_d;
      wr_addr      <= wr_addr_d;
      wr_data      <= wr_data_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_vpu_vec_engine.sv
// Self-checking bench for vpu_vec_engine: a memory responder with selectable
// backpressure and a behavioural reference model of the instruction semantics.
`timescale 1ns/1ps
module tb_vpu_vec_engine;
  import vpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [INST_W-1:0] inst;
  logic              inst_valid, inst_ready;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_resp_valid;
  logic [WORD_W-1:0] rd_resp_data;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              busy, done, err;

  always #5 clk = ~clk;

  vpu_vec_engine dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [WORD_W-1:0] obs,
                           input logic [WORD_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory image and responder state, all owned by the main process.
  logic [WORD_W-1:0] mem [0:65535];
  bit                pend, prev_rstall, prev_wstall, spur, hold_wr;
  int                pend_addr, rcnt, wcnt, rd_cnt, mode;
  logic [ADDR_W-1:0] prev_raddr, prev_waddr;
  logic [WORD_W-1:0] prev_wdata;
  int                wr_log_addr[$];
  logic [WORD_W-1:0] wr_log_data[$];

  // mode 0: always ready; 1: random ready; 2: ready only after 5 stalled cycles.
  function automatic logic pick_ready(input int waited);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 1) == 1);
      default: return (waited >= 5);
    endcase
  endfunction

  // Advance to the next falling edge and play the memory side.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      pend = 0; prev_rstall = 0; prev_wstall = 0; rcnt = 0; wcnt = 0;
      rd_resp_valid = 1'b0; rd_req_ready = 1'b0; wr_ready = 1'b0;
      return;
    end
    if (prev_rstall) begin
      check_val("rd_valid_hold", WORD_W'(rd_req_valid), WORD_W'(1));
      check_val("rd_addr_hold", WORD_W'(rd_addr), WORD_W'(prev_raddr));
    end
    if (prev_wstall) begin
      check_val("wr_valid_hold", WORD_W'(wr_valid), WORD_W'(1));
      check_val("wr_addr_hold", WORD_W'(wr_addr), WORD_W'(prev_waddr));
      check_val("wr_data_hold", wr_data, prev_wdata);
    end
    if (pend) begin
      rd_resp_valid = 1'b1;
      rd_resp_data  = mem[pend_addr];
      pend = 0;
    end else begin
      rd_resp_valid = spur && ($urandom_range(0, 3) == 0);
      rd_resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    rd_req_ready = pick_ready(rcnt);
    if (rd_req_valid) begin
      if (rd_req_ready) begin
        pend = 1; pend_addr = int'(rd_addr); rd_cnt++; rcnt = 0;
      end else rcnt++;
    end
    prev_rstall = rd_req_valid && !rd_req_ready;
    prev_raddr  = rd_addr;
    wr_ready = hold_wr ? 1'b0 : pick_ready(wcnt);
    if (wr_valid) begin
      if (wr_ready) begin
        wr_log_addr.push_back(int'(wr_addr));
        wr_log_data.push_back(wr_data);
        mem[wr_addr] = wr_data;
        wcnt = 0;
      end else wcnt++;
    end
    prev_wstall = wr_valid && !wr_ready;
    prev_waddr  = wr_addr;
    prev_wdata  = wr_data;
  endtask

  // Reference semantics of one lane.
  function automatic logic [31:0] lane_ref(input int op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] k);
    logic [63:0] p;
    int sa, sb;
    sa = a; sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a + k;
      3: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      4: return (sa > sb) ? a : b;
      5: return (sa < sb) ? a : b;
      6: return (sa < 0) ? 32'd0 : a;
      7: begin p = {32'd0, a} * {32'd0, k}; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] word4(input logic [31:0] l0, input logic [31:0] l1,
                                              input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic vpu_inst_t mk(input int op, input int a, input int b, input int c,
                                   input int k, input int len);
    vpu_inst_t r;
    r.opcode = OP_W'(op); r.a_addr = INST_ADDR'(a); r.b_addr = INST_ADDR'(b);
    r.c_addr = INST_ADDR'(c); r.const_addr = INST_ADDR'(k); r.len = LEN_W'(len);
    return r;
  endfunction

  // Issue one instruction, wait for retirement and compare against the model.
  task automatic run_inst(input vpu_inst_t ins, input bit chk_lat);
    logic [WORD_W-1:0] ovl [int];
    int                exp_addr[$];
    logic [WORD_W-1:0] exp_data[$];
    logic [WORD_W-1:0] wa, wb, w;
    logic [31:0]       kk;
    int op, beats, exp_rd, lat, rd0, wr0, c, ia, ib, ic, n;
    bit bin, cst, illegal;
    op      = int'(ins.opcode);
    illegal = (op > 7);
    bin     = op inside {0, 1, 3, 4, 5};
    cst     = (op == 2) || (op == 7);
    beats   = int'(ins.len) + 1;
    kk      = mem[ins.const_addr][31:0];
    if (!illegal) begin
      for (int bt = 0; bt < beats; bt++) begin
        ia = (int'(ins.a_addr) + bt) % 65536;
        ib = (int'(ins.b_addr) + bt) % 65536;
        ic = (int'(ins.c_addr) + bt) % 65536;
        wa = ovl.exists(ia) ? ovl[ia] : mem[ia];
        wb = ovl.exists(ib) ? ovl[ib] : mem[ib];
        for (int l = 0; l < LANES; l++)
          w[l*32 +: 32] = lane_ref(op, wa[l*32 +: 32], wb[l*32 +: 32], kk);
        ovl[ic] = w;
        exp_addr.push_back(ic);
        exp_data.push_back(w);
      end
    end
    exp_rd = illegal ? 0 : (cst ? 1 : 0) + beats * (bin ? 2 : 1);
    lat    = illegal ? 1 : beats * (bin ? 6 : 4) + (cst ? 2 : 0) + 1;
    rd0 = rd_cnt;
    wr0 = wr_log_addr.size();
    check_val("inst_ready_idle", WORD_W'(inst_ready), WORD_W'(1));
    inst = ins; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    c = 1;
    check_val("busy_after_accept", WORD_W'(busy), WORD_W'(1));
    while (!done && c < 4000) begin step(); c++; end
    check_val("done_seen", WORD_W'(done), WORD_W'(1));
    check_val("err", WORD_W'(err), WORD_W'(illegal));
    if (chk_lat) check_val("latency", WORD_W'(c), WORD_W'(lat));
    check_val("rd_count", WORD_W'(rd_cnt - rd0), WORD_W'(exp_rd));
    n = wr_log_addr.size() - wr0;
    check_val("wr_count", WORD_W'(n), WORD_W'(exp_addr.size()));
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      check_val("wr_addr", WORD_W'(wr_log_addr[wr0+i]), WORD_W'(exp_addr[i]));
      check_val("wr_data", wr_log_data[wr0+i], exp_data[i]);
    end
    step();
    check_val("done_pulse_end", WORD_W'(done), WORD_W'(0));
    check_val("inst_ready_back", WORD_W'(inst_ready), WORD_W'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vpu_inst_t         ins;
    logic [WORD_W-1:0] exp0, orig32;
    int                rd0, wr0, c;

    rst = 1'b1; inst = '0; inst_valid = 1'b0;
    rd_req_ready = 1'b0; rd_resp_valid = 1'b0; rd_resp_data = '0; wr_ready = 1'b0;
    pend = 0; prev_rstall = 0; prev_wstall = 0; rcnt = 0; wcnt = 0; rd_cnt = 0;
    mode = 0; spur = 0; hold_wr = 0; pend_addr = 0;
    prev_raddr = '0; prev_waddr = '0; prev_wdata = '0;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

    // Reset values.
    #12;
    check_val("rst_inst_ready", WORD_W'(inst_ready), WORD_W'(1));
    check_val("rst_busy", WORD_W'(busy), WORD_W'(0));
    check_val("rst_rd_req_valid", WORD_W'(rd_req_valid), WORD_W'(0));
    check_val("rst_wr_valid", WORD_W'(wr_valid), WORD_W'(0));
    check_val("rst_done_err", WORD_W'({done, err}), WORD_W'(0));
    step(); step();
    rst = 1'b0;
    step();

    // ADD, single beat.
    mem[1] = word4(1, 2, 3, 4);
    mem[2] = word4(10, 20, 30, 40);
    run_inst(mk(0, 1, 2, 3, 0, 0), 1);
    check_val("add_result", mem[3], word4(11, 22, 33, 44));

    // ADDC, three beats, k read once, no B reads.
    mem[5] = word4(100, 32'hDEAD, 32'hBEEF, 32'h1234);
    for (int i = 8; i <= 10; i++) mem[i] = word4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd0 = rd_cnt;
    run_inst(mk(2, 8, 0, 12, 5, 2), 1);
    check_val("addc_reads", WORD_W'(rd_cnt - rd0), WORD_W'(4));
    for (int i = 12; i <= 14; i++) check_val("addc_result", mem[i], word4(99, 99, 99, 99));

    // Signed/overflow corners.
    mem[16] = word4(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 7);
    mem[17] = word4(32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF);
    run_inst(mk(3, 16, 17, 20, 0, 0), 1);
    check_val("mul_corner", mem[20], word4(32'h80000000, 32'h80000000, 0, 32'hFFFFFFF9));
    run_inst(mk(4, 16, 17, 21, 0, 0), 1);
    check_val("max_corner", mem[21], word4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 7));
    run_inst(mk(5, 16, 17, 22, 0, 0), 1);
    check_val("min_corner", mem[22], word4(32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF));
    run_inst(mk(6, 16, 0, 23, 0, 0), 1);
    check_val("relu_corner", mem[23], word4(0, 0, 0, 7));

    // Illegal opcode: no traffic, done+err one cycle after accept.
    run_inst(mk(12, 1, 2, 3, 4, 7), 1);

    // Backpressure: fixed 5-cycle stalls, then random stalls with stray responses.
    mode = 2;
    run_inst(mk(1, 1, 2, 24, 0, 3), 0);
    run_inst(mk(7, 8, 0, 25, 5, 2), 0);
    mode = 1; spur = 1;
    run_inst(mk(3, 16, 17, 26, 0, 4), 0);
    mode = 0; spur = 0;

    // Reset during the second write of a 3-beat SUB.
    ins = mk(1, 1, 10, 31, 0, 2);
    for (int l = 0; l < LANES; l++)
      exp0[l*32 +: 32] = lane_ref(1, mem[1][l*32 +: 32], mem[10][l*32 +: 32], 0);
    orig32 = mem[32];
    wr0 = wr_log_addr.size();
    inst = ins; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    c = 0;
    while (wr_log_addr.size() == wr0 && c < 200) begin step(); c++; end
    hold_wr = 1;
    c = 0;
    while (!(wr_valid && wr_addr == ADDR_W'(32)) && c < 200) begin step(); c++; end
    check_val("reach_wr_beat1", WORD_W'(wr_valid && wr_addr == ADDR_W'(32)), WORD_W'(1));
    #2 rst = 1'b1;
    #1;
    check_val("arst_rd_req_valid", WORD_W'(rd_req_valid), WORD_W'(0));
    check_val("arst_wr_valid", WORD_W'(wr_valid), WORD_W'(0));
    check_val("arst_busy", WORD_W'(busy), WORD_W'(0));
    check_val("arst_done_err", WORD_W'({done, err}), WORD_W'(0));
    check_val("arst_addrs", WORD_W'({rd_addr, wr_addr}), WORD_W'(0));
    check_val("arst_wr_data", wr_data, '0);
    check_val("arst_inst_ready", WORD_W'(inst_ready), WORD_W'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("arst_no_done", WORD_W'(done), WORD_W'(0));
    end
    rst = 1'b0; hold_wr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("post_rst_idle", WORD_W'({done, busy}), WORD_W'(0));
    end
    check_val("partial_wr_count", WORD_W'(wr_log_addr.size() - wr0), WORD_W'(1));
    check_val("partial_wr_beat0", mem[31], exp0);
    check_val("partial_wr_beat1_absent", mem[32], orig32);
    run_inst(ins, 1);

    // Randomized instructions under all backpressure modes.
    spur = 1;
    for (int it = 0; it < 40; it++) begin
      int op;
      mode = $urandom_range(0, 2);
      op = ($urandom_range(0, 8) == 8) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      run_inst(mk(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 15)), (mode == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
